tpmem_frame_ctrl: RTL and testbench
===================================

# tpmem_frame_ctrl

Frame sequencer placed directly in front of the stage-2 truncated transpose memory. It accepts 16-row frames from the upstream stage over a valid/ready handshake and forwards each row, registered, to the memory's write port. It blocks upstream for the memory's 16-cycle column read-out and monitors the memory's column strobe, counting completed frames and flagging protocol errors. It also owns the memory's active-low reset, so a flush can clear the memory without a global reset.

## Interface
Parameters:
- BW, 12, element width; a row is 16 elements.
- FRAMES_W, 8, width of the completed-frame counter.

Ports:
- i_clk  in  1  clock; the block uses one clock.
- i_Reset  in  1  reset; synchronous and active-high.
- i_flush  in  1  single-cycle request to abort the current frame and clear the memory.
- i_data  in  16*BW  upstream row.
- i_valid  in  1  upstream row valid.
- o_ready  out  1  row accepted when i_valid & o_ready.
- o_tp_data  out  16*BW  registered row to the memory's i_data.
- o_tp_en  out  1  registered write enable to the memory's i_enable.
- o_tp_rstn  out  1  active-low synchronous reset to the memory.
- i_tp_en  in  1  memory column-valid (memory o_en).
- o_col_idx  out  4  index of the column currently presented by the memory.
- o_frame_done  out  1  one-cycle pulse after the 16th column.
- o_frame_cnt  out  FRAMES_W  completed frames, wraps at 2^FRAMES_W.
- o_err  out  1  sticky protocol error.

## Operation
States:
- LOAD
  - o_ready=1.
  - row_cnt counts accepted beats 0..15.
  - On the 16th accept, go to DRAIN and set drain_cnt=0.
- DRAIN
  - o_ready=0 for exactly 16 cycles (drain_cnt 0..15).
  - At drain_cnt=15, go to LOAD.
  - Purpose: the memory must never see i_enable while its internal counter is in 16..31, because a write there corrupts stored rows.
- FLUSH
  - Entered from any state on i_flush.
  - o_tp_rstn=0 and o_ready=0 for 2 cycles.
  - row_cnt, drain_cnt, col_cnt and pending are cleared.
  - Then go to LOAD.
  - o_frame_cnt and o_err are preserved.

Write path:
- o_tp_data <= i_data and o_tp_en <= (i_valid & o_ready), every cycle.
- When no beat is accepted, o_tp_data is held.
- o_tp_en is forced to 0 in FLUSH.

Column monitor:
- pending is set when the 16th row is written and cleared when the 16th column is seen.
- col_cnt increments on each i_tp_en and wraps 15→0. o_col_idx = col_cnt.
- When col_cnt=15 and i_tp_en=1: o_frame_done pulses in the next cycle, o_frame_cnt increments, and pending clears.
- o_err is set when any of these occurs:
  - i_tp_en=1 with pending=0;
  - i_tp_en=0 while col_cnt≠0 (gap inside a column burst);
  - i_flush while in DRAIN.
- o_err is cleared only by i_Reset.

Boundary cases:
- Upstream gaps in LOAD are allowed; row_cnt holds.
- i_flush and an accept in the same cycle: flush wins and the beat is dropped.
- i_Reset in any state: all registers clear and the next cycle is LOAD.
- o_tp_rstn is also driven 0 while i_Reset=1.

## Timing
Reset values:
- o_ready=0 during reset, then 1 in the first cycle after reset (LOAD).
- o_tp_en=0, o_tp_data=0, o_tp_rstn=0, o_col_idx=0, o_frame_done=0, o_frame_cnt=0, o_err=0.

Sequence for a 16th row accepted in cycle n:
- o_tp_en=1 in cycle n+1.
- Memory counter reaches 16 in cycle n+2.
- Memory columns arrive on i_tp_en in cycles n+3..n+18.
- o_ready=0 in cycles n+1..n+16; o_ready=1 again in n+17 (earliest next accept).
- The first write of the next frame occurs in n+18, when the memory counter is back at 0.
- o_frame_done in cycle n+19.

Throughput and latency:
- Back-to-back frames: 32 cycles/frame.
- Row-to-write latency: 1 cycle.

## Test plan
- Reset, then 16 rows with i_valid held high (row r = all elements r) → o_ready low exactly 16 cycles starting the cycle after the last accept; o_frame_done 19 cycles after the last accept; o_frame_cnt=1; o_err=0.
- Three back-to-back frames with continuous valid → 32-cycle period; no o_tp_en while the memory's o_en is high; o_frame_cnt=3; transposed columns match the golden model.
- Random i_valid gaps (50%) over 2 frames → exactly 32 o_tp_en pulses; row order preserved; o_err=0.
- i_flush after 7 rows → o_tp_rstn low 2 cycles; the next 16 rows form a clean frame; o_frame_cnt unchanged until it completes; o_err=0.
- i_flush during DRAIN → o_err=1 and stays 1 through the following good frame; i_Reset clears it.
- Forced spurious i_tp_en pulse while idle → o_err=1; o_frame_cnt unchanged.

Source files
------------

// File: rtl/tpmem_frame_ctrl.sv
// Frame sequencer in front of the stage-2 transpose memory: loads 16-row frames,
// stalls upstream during the 16-cycle column read-out and watches the column strobe.
module tpmem_frame_ctrl #(
  parameter int BW       = 12,
  parameter int FRAMES_W = 8
) (
  input  logic                i_clk,
  input  logic                i_Reset,
  input  logic                i_flush,
  input  logic [16*BW-1:0]    i_data,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [16*BW-1:0]    o_tp_data,
  output logic                o_tp_en,
  output logic                o_tp_rstn,
  input  logic                i_tp_en,
  output logic [3:0]          o_col_idx,
  output logic                o_frame_done,
  output logic [FRAMES_W-1:0] o_frame_cnt,
  output logic                o_err
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_row_cnt;
  logic [3:0]          r_drain_cnt;
  logic [3:0]          r_col_cnt;
  logic                r_flush_cnt;
  logic                r_pending;
  logic                r_frame_done;
  logic                r_err;
  logic [FRAMES_W-1:0] r_frame_cnt;
  logic [16*BW-1:0]    r_tp_data;
  logic                r_tp_en;

  logic                w_accept;
  logic                w_last_row;
  logic                w_mon;
  logic                w_col_last;
  logic                w_err_evt;

  assign o_ready    = ~i_Reset & (r_state == LOAD);
  assign w_accept   = i_valid & o_ready & ~i_flush;
  assign w_last_row = w_accept & (r_row_cnt == 4'd15);
  assign o_tp_rstn  = ~i_Reset & (r_state != FLUSH);

  // The strobe is meaningless while the memory is held in reset, so the monitor ignores it.
  assign w_mon      = (r_state != FLUSH);
  assign w_col_last = w_mon & i_tp_en & (r_col_cnt == 4'd15);
  assign w_err_evt  = (w_mon & i_tp_en & ~r_pending)
                    | (w_mon & ~i_tp_en & (r_col_cnt != 4'd0))
                    | (i_flush & (r_state == DRAIN));

  assign o_tp_data    = r_tp_data;
  assign o_tp_en      = r_tp_en;
  assign o_col_idx    = r_col_cnt;
  assign o_frame_done = r_frame_done;
  assign o_frame_cnt  = r_frame_cnt;
  assign o_err        = r_err;

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = FLUSH;
    end else begin
      case (r_state)
        LOAD:    if (w_last_row) w_state_nxt = DRAIN;
        DRAIN:   if (r_drain_cnt == 4'd15) w_state_nxt = LOAD;
        FLUSH:   if (r_flush_cnt) w_state_nxt = LOAD;
        default: w_state_nxt = LOAD;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_Reset) begin
      r_state     <= LOAD;
      r_row_cnt   <= 4'd0;
      r_drain_cnt <= 4'd0;
      r_flush_cnt <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (i_flush) begin
        r_row_cnt   <= 4'd0;
        r_drain_cnt <= 4'd0;
        r_flush_cnt <= 1'b0;
      end else begin
        case (r_state)
          LOAD: begin
            if (w_accept) r_row_cnt <= r_row_cnt + 4'd1;
            r_drain_cnt <= 4'd0;
          end
          DRAIN:   r_drain_cnt <= r_drain_cnt + 4'd1;
          FLUSH:   r_flush_cnt <= 1'b1;
          default: r_row_cnt <= 4'd0;
        endcase
      end
    end
  end

  // Write enable is the registered accept; it is already low in FLUSH because o_ready is.
  always_ff @(posedge i_clk) begin
    if (i_Reset) begin
      r_tp_data <= '0;
      r_tp_en   <= 1'b0;
    end else begin
      r_tp_en <= w_accept;
      if (w_accept) r_tp_data <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_Reset) begin
      r_col_cnt    <= 4'd0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_frame_done <= w_col_last;
      if (w_col_last) r_frame_cnt <= r_frame_cnt + FRAMES_W'(1);
      if (w_err_evt) r_err <= 1'b1;
      if (i_flush || !w_mon) begin
        r_col_cnt <= 4'd0;
        r_pending <= 1'b0;
      end else begin
        if (i_tp_en) r_col_cnt <= r_col_cnt + 4'd1;
        if (w_col_last) r_pending <= 1'b0;
        else if (w_last_row) r_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tpmem_frame_ctrl.sv
// Bench for tpmem_frame_ctrl: a cycle-timed frame model plus a behavioural
// transpose-memory counter that returns the 16 column strobes.
module tb_tpmem_frame_ctrl;
  localparam int BW = 12;
  localparam int FW = 8;
  localparam int DW = 16 * BW;

  logic          clk = 1'b0;
  logic          rst, flush, valid;
  logic [DW-1:0] data;
  logic          ready, tpEnOut, tpRstn, tpEnIn, frameDone, err;
  logic [DW-1:0] tpData;
  logic [3:0]    colIdx;
  logic [FW-1:0] frameCnt;
  logic          forceEn = 1'b0;
  logic          memEn = 1'b0;
  int            mcnt = 0;

  always #5 clk = ~clk;
  assign tpEnIn = memEn | forceEn;

  tpmem_frame_ctrl #(.BW(BW), .FRAMES_W(FW)) dut (
    .i_clk(clk), .i_Reset(rst), .i_flush(flush), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_tp_data(tpData), .o_tp_en(tpEnOut), .o_tp_rstn(tpRstn),
    .i_tp_en(tpEnIn), .o_col_idx(colIdx), .o_frame_done(frameDone),
    .o_frame_cnt(frameCnt), .o_err(err)
  );

  // Memory: 16 writes fill it, then the counter free-runs 16..31 presenting columns.
  always @(posedge clk) begin
    if (tpRstn !== 1'b1) begin
      mcnt  <= 0;
      memEn <= 1'b0;
    end else begin
      if (mcnt >= 16) mcnt <= (mcnt == 31) ? 0 : mcnt + 1;
      else if (tpEnOut === 1'b1) mcnt <= mcnt + 1;
      memEn <= (mcnt >= 16);
    end
  end

  int total = 0;
  int bad = 0;

  int cyc = 0, blockEnd = 0, rstnEnd = 0, drainLo = -1, drainHi = -1;
  int doneAt = -1, colBase = -1, rowsIn = 0, accepted = 0, expFrames = 0;
  bit expErr = 1'b0, expTpEn = 1'b0;
  logic [DW-1:0] expData = '0;

  bit eReady, eRstn, eDone, eTpEn, eErr;
  int eCol, eFrames;
  logic [DW-1:0] eData;

  logic obsReady, obsRstn, obsTpEn, obsDone, obsErr;
  logic [3:0] obsCol;
  logic [FW-1:0] obsFrames;
  logic [DW-1:0] obsData;
  int obsMcnt;

  function automatic logic [DW-1:0] rowOf(input int r);
    logic [BW-1:0] e;
    e = r[BW-1:0];
    return {16{e}};
  endfunction

  function automatic logic [DW-1:0] randRow();
    logic [DW-1:0] v;
    for (int j = 0; j < DW / 32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock cycle: drive inputs, sample the DUT, then advance the timing model.
  task automatic step(input bit r, input bit v, input bit f, input logic [DW-1:0] d, input bit fe);
    bit acc;
    @(posedge clk);
    #1;
    rst = r; valid = v; flush = f; data = d; forceEn = fe;
    #1;
    obsReady = ready; obsRstn = tpRstn; obsTpEn = tpEnOut; obsDone = frameDone;
    obsErr = err; obsCol = colIdx; obsFrames = frameCnt; obsData = tpData; obsMcnt = mcnt;
    eReady = !r && (cyc >= blockEnd);
    eRstn  = !r && (cyc >= rstnEnd);
    eDone  = (cyc == doneAt);
    if (eDone) begin
      expFrames = (expFrames + 1) % (1 << FW);
      doneAt = -1;
    end
    eCol = (colBase >= 0 && cyc >= colBase && cyc <= colBase + 15) ? cyc - colBase : 0;
    eTpEn = expTpEn; eData = expData; eErr = expErr; eFrames = expFrames;
    acc = v && eReady && !f;
    if (r) begin
      blockEnd = cyc + 1; rstnEnd = cyc + 1; drainLo = -1; drainHi = -1;
      doneAt = -1; colBase = -1; rowsIn = 0; expFrames = 0; expErr = 0;
      expTpEn = 0; expData = '0;
    end else begin
      expTpEn = acc;
      if (acc) begin
        expData = d;
        accepted++;
        rowsIn++;
        if (rowsIn == 16) begin
          rowsIn = 0; blockEnd = cyc + 17; drainLo = cyc + 1; drainHi = cyc + 16;
          doneAt = cyc + 19; colBase = cyc + 3;
        end
      end
      if (fe && doneAt < 0) expErr = 1;
      if (f) begin
        if (cyc >= drainLo && cyc <= drainHi) expErr = 1;
        rowsIn = 0; blockEnd = cyc + 3; rstnEnd = cyc + 3;
        doneAt = -1; colBase = -1; drainLo = -1; drainHi = -1;
      end
    end
    cyc++;
  endtask

  task automatic applyStimulusReset();
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, randRow(), 0);
      total++; if (obsReady !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b want=0", obsReady); end
      total++; if (obsRstn !== 1'b0) begin bad++; $display("[TB] FAIL reset_rstn got=%b want=0", obsRstn); end
    end
    step(0, 0, 0, '0, 0);
    total++; if (obsReady !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_ready got=%b want=1", obsReady); end
    total++; if (obsRstn !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_rstn got=%b want=1", obsRstn); end
    total++; if (obsTpEn !== 1'b0) begin bad++; $display("[TB] FAIL reset_tp_en got=%b want=0", obsTpEn); end
    total++; if (obsData !== '0) begin bad++; $display("[TB] FAIL reset_tp_data got=%h want=0", obsData); end
    total++; if (obsCol !== 4'd0) begin bad++; $display("[TB] FAIL reset_col got=%0d want=0", obsCol); end
    total++; if (obsDone !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", obsDone); end
    total++; if (obsFrames !== '0) begin bad++; $display("[TB] FAIL reset_frames got=%0d want=0", obsFrames); end
    total++; if (obsErr !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b want=0", obsErr); end
  endtask

  task automatic test_single_frame();
    int r = 0, lowCnt = 0, lastAcc = -1, doneCyc = -1, a;
    applyStimulusReset();
    for (int i = 0; i < 40; i++) begin
      a = accepted;
      step(0, r < 16, 0, rowOf(r), 0);
      if (accepted != a) begin r++; if (r == 16) lastAcc = cyc - 1; end
      else if (r == 16 && obsReady === 1'b0) lowCnt++;
      if (obsDone === 1'b1) doneCyc = cyc - 1;
      total++; if (obsReady !== eReady) begin bad++; $display("[TB] FAIL single_ready cyc=%0d got=%b want=%b", cyc - 1, obsReady, eReady); end
      total++; if (obsTpEn !== eTpEn) begin bad++; $display("[TB] FAIL single_tp_en cyc=%0d got=%b want=%b", cyc - 1, obsTpEn, eTpEn); end
      total++; if (obsCol !== eCol[3:0]) begin bad++; $display("[TB] FAIL single_col cyc=%0d got=%0d want=%0d", cyc - 1, obsCol, eCol); end
      if (eTpEn) begin
        total++; if (obsData !== eData) begin bad++; $display("[TB] FAIL single_data cyc=%0d got=%h want=%h", cyc - 1, obsData, eData); end
      end
    end
    total++; if (lowCnt != 16) begin bad++; $display("[TB] FAIL single_ready_low got=%0d want=16", lowCnt); end
    total++; if (doneCyc - lastAcc != 19) begin bad++; $display("[TB] FAIL single_done_latency got=%0d want=19", doneCyc - lastAcc); end
    total++; if (obsFrames !== 8'd1) begin bad++; $display("[TB] FAIL single_frames got=%0d want=1", obsFrames); end
    total++; if (obsErr !== 1'b0) begin bad++; $display("[TB] FAIL single_err got=%b want=0", obsErr); end
  endtask

  task automatic test_back_to_back();
    int a0, dones[$];
    applyStimulusReset();
    a0 = accepted;
    for (int i = 0; i < 110; i++) begin
      step(0, (accepted - a0) < 48, 0, randRow(), 0);
      if (obsDone === 1'b1) dones.push_back(cyc - 1);
      total++; if (obsReady !== eReady) begin bad++; $display("[TB] FAIL b2b_ready cyc=%0d got=%b want=%b", cyc - 1, obsReady, eReady); end
      total++; if (obsTpEn === 1'b1 && obsMcnt >= 16) begin bad++; $display("[TB] FAIL b2b_write_in_readout cyc=%0d got=%0d want=<16", cyc - 1, obsMcnt); end
      if (eTpEn) begin
        total++; if (obsData !== eData) begin bad++; $display("[TB] FAIL b2b_data cyc=%0d got=%h want=%h", cyc - 1, obsData, eData); end
      end
    end
    total++; if (dones.size() != 3) begin bad++; $display("[TB] FAIL b2b_done_count got=%0d want=3", dones.size()); end
    for (int k = 1; k < dones.size(); k++) begin
      total++; if (dones[k] - dones[k-1] != 32) begin bad++; $display("[TB] FAIL b2b_period got=%0d want=32", dones[k] - dones[k-1]); end
    end
    total++; if (obsFrames !== 8'd3) begin bad++; $display("[TB] FAIL b2b_frames got=%0d want=3", obsFrames); end
  endtask

  task automatic test_random_gaps();
    int a0, a, writes = 0;
    logic [DW-1:0] d, q[$];
    applyStimulusReset();
    a0 = accepted;
    for (int i = 0; i < 300; i++) begin
      d = randRow();
      a = accepted;
      step(0, ((accepted - a0) < 32) && ($urandom % 2 == 1), 0, d, 0);
      if (accepted != a) q.push_back(d);
      total++; if (obsReady !== eReady) begin bad++; $display("[TB] FAIL gaps_ready cyc=%0d got=%b want=%b", cyc - 1, obsReady, eReady); end
      if (obsTpEn === 1'b1) begin
        writes++;
        total++;
        if (q.size() == 0) begin bad++; $display("[TB] FAIL gaps_extra_write cyc=%0d got=1 want=0", cyc - 1); end
        else begin d = q.pop_front(); if (obsData !== d) begin bad++; $display("[TB] FAIL gaps_order cyc=%0d got=%h want=%h", cyc - 1, obsData, d); end end
      end
    end
    total++; if (accepted - a0 != 32) begin bad++; $display("[TB] FAIL gaps_accepts got=%0d want=32", accepted - a0); end
    total++; if (writes != 32) begin bad++; $display("[TB] FAIL gaps_writes got=%0d want=32", writes); end
    total++; if (obsFrames !== 8'd2) begin bad++; $display("[TB] FAIL gaps_frames got=%0d want=2", obsFrames); end
    total++; if (obsErr !== 1'b0) begin bad++; $display("[TB] FAIL gaps_err got=%b want=0", obsErr); end
  endtask

  task automatic test_flush_load();
    int a0, rstnLow = 0;
    applyStimulusReset();
    a0 = accepted;
    for (int i = 0; i < 50; i++) begin
      step(0, (i <= 7) || (i >= 10 && (accepted - a0) < 23), i == 7, rowOf(i + 100), 0);
      if (obsRstn === 1'b0) rstnLow++;
      total++; if (obsReady !== eReady) begin bad++; $display("[TB] FAIL flushld_ready cyc=%0d got=%b want=%b", cyc - 1, obsReady, eReady); end
      total++; if (obsRstn !== eRstn) begin bad++; $display("[TB] FAIL flushld_rstn cyc=%0d got=%b want=%b", cyc - 1, obsRstn, eRstn); end
      total++; if (obsTpEn !== eTpEn) begin bad++; $display("[TB] FAIL flushld_tp_en cyc=%0d got=%b want=%b", cyc - 1, obsTpEn, eTpEn); end
      total++; if (obsFrames !== eFrames[FW-1:0]) begin bad++; $display("[TB] FAIL flushld_frames cyc=%0d got=%0d want=%0d", cyc - 1, obsFrames, eFrames); end
      if (eTpEn) begin
        total++; if (obsData !== eData) begin bad++; $display("[TB] FAIL flushld_data cyc=%0d got=%h want=%h", cyc - 1, obsData, eData); end
      end
    end
    total++; if (rstnLow != 2) begin bad++; $display("[TB] FAIL flushld_rstn_low got=%0d want=2", rstnLow); end
    total++; if (obsFrames !== 8'd1) begin bad++; $display("[TB] FAIL flushld_final_frames got=%0d want=1", obsFrames); end
    total++; if (obsErr !== 1'b0) begin bad++; $display("[TB] FAIL flushld_err got=%b want=0", obsErr); end
  endtask

  task automatic test_flush_drain();
    int a0;
    applyStimulusReset();
    a0 = accepted;
    for (int i = 0; i < 65; i++) begin
      step(0, (i < 16) || (i >= 23 && (accepted - a0) < 32), i == 20, rowOf(i), 0);
      total++; if (obsErr !== eErr) begin bad++; $display("[TB] FAIL flushdr_err cyc=%0d got=%b want=%b", cyc - 1, obsErr, eErr); end
      total++; if (obsReady !== eReady) begin bad++; $display("[TB] FAIL flushdr_ready cyc=%0d got=%b want=%b", cyc - 1, obsReady, eReady); end
      total++; if (obsTpEn !== eTpEn) begin bad++; $display("[TB] FAIL flushdr_tp_en cyc=%0d got=%b want=%b", cyc - 1, obsTpEn, eTpEn); end
      total++; if (obsFrames !== eFrames[FW-1:0]) begin bad++; $display("[TB] FAIL flushdr_frames cyc=%0d got=%0d want=%0d", cyc - 1, obsFrames, eFrames); end
    end
    total++; if (obsErr !== 1'b1) begin bad++; $display("[TB] FAIL flushdr_err_sticky got=%b want=1", obsErr); end
    total++; if (obsFrames !== 8'd1) begin bad++; $display("[TB] FAIL flushdr_final_frames got=%0d want=1", obsFrames); end
    step(1, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    total++; if (obsErr !== 1'b0) begin bad++; $display("[TB] FAIL flushdr_err_cleared got=%b want=0", obsErr); end
  endtask

  task automatic test_spurious();
    applyStimulusReset();
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, '0, i == 3);
      total++; if (obsErr !== eErr) begin bad++; $display("[TB] FAIL spur_err cyc=%0d got=%b want=%b", cyc - 1, obsErr, eErr); end
      total++; if (obsFrames !== eFrames[FW-1:0]) begin bad++; $display("[TB] FAIL spur_frames cyc=%0d got=%0d want=%0d", cyc - 1, obsFrames, eFrames); end
    end
    total++; if (obsErr !== 1'b1) begin bad++; $display("[TB] FAIL spur_err_final got=%b want=1", obsErr); end
    total++; if (obsFrames !== 8'd0) begin bad++; $display("[TB] FAIL spur_frames_final got=%0d want=0", obsFrames); end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; flush = 1'b0; data = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_random_gaps();
    test_flush_load();
    test_flush_drain();
    test_spurious();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
